mmio_port_bank: RTL and testbench

//  Parametrised memory-mapped IO block; successor to the fixed 4-bit IN/OUT pair decoded inline in the datapath.

---
 rtl/mmio_port_bank_pkg.sv | 10 +
 rtl/mmio_port_bank_if.sv | 15 +
 rtl/mmio_port_bank_io_sync_edge.sv | 26 ++
 rtl/mmio_port_bank.sv | 85 ++++++++
 tb/tb_mmio_port_bank.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_port_bank_pkg.sv
// mmio_port_bank_pkg: register offsets within a port window and the default bank base address
package mmio_port_bank_pkg;
  typedef enum logic [1:0] {
    MMIO_OUT  = 2'd0,
    MMIO_IN   = 2'd1,
    MMIO_EDGE = 2'd2,
    MMIO_MASK = 2'd3
  } mmio_reg_e;
  localparam logic [9:0] DEFAULT_BASE_ADDR = 10'h3C0;
endpackage

// File: rtl/mmio_port_bank_if.sv
// mmio_port_bank_if: DAR/MDR-side bus (addr, wr_en/wr_data, rd_en, rd_data/rd_valid, hit); master drives, slave is the bank
interface mmio_port_bank_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) ();
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              hit;
  modport master (output addr, wr_en, wr_data, rd_en, input rd_data, rd_valid, hit);
  modport slave  (input addr, wr_en, wr_data, rd_en, output rd_data, rd_valid, hit);
endinterface

// File: rtl/mmio_port_bank_io_sync_edge.sv
// io_sync_edge: STAGES-deep pin synchroniser (d_async -> q) with prev-sample change detect on edge_pulse, gated by primed
module io_sync_edge #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_async,
  input  logic         primed,
  output logic [W-1:0] q,
  output logic [W-1:0] edge_pulse
);
  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]             prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_async};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign q          = sync_q[STAGES-1];
  assign edge_pulse = primed ? q ^ prev_q : '0;
endmodule

// File: rtl/mmio_port_bank.sv
// mmio_port_bank: N_PORTS x {OUT, IN, EDGE(W1C), MASK} MMIO ports on bus (slave), pins io_in/io_out, irq = |(EDGE & MASK)
module mmio_port_bank
  import mmio_port_bank_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 10,
  parameter int                IO_W        = 4,
  parameter int                N_PORTS     = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mmio_port_bank_if.slave         bus,
  input  logic [N_PORTS*IO_W-1:0] io_in,
  output logic [N_PORTS*IO_W-1:0] io_out,
  output logic                    irq
);
  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  logic [CNT_W-1:0]        prime_cnt;
  logic                    primed;
  logic [ADDR_W-1:0]       off;
  logic                    hit;
  mmio_reg_e               r;
  logic [N_PORTS-1:0]      sel_v;
  logic [N_PORTS-1:0]      pend_v;
  logic [N_PORTS*IO_W-1:0] fld_all;
  logic [DATA_W-1:0]       rd_mux;
  logic [DATA_W-1:0]       rd_data_q;
  logic                    rd_valid_q;
  assign primed = prime_cnt == CNT_W'(SYNC_STAGES + 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prime_cnt <= '0;
    else if (!primed) prime_cnt <= prime_cnt + CNT_W'(1);
  end
  assign off     = bus.addr - BASE_ADDR;
  assign hit     = bus.addr >= BASE_ADDR && off < ADDR_W'(4 * N_PORTS);
  assign r       = mmio_reg_e'(off[1:0]);
  assign bus.hit = hit;
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [IO_W-1:0] out_q, mask_q, edge_q, in_q, pulse;
    logic            wr_sel;
    io_sync_edge #(.W(IO_W), .STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .d_async   (io_in[p*IO_W +: IO_W]),
      .primed    (primed),
      .q         (in_q),
      .edge_pulse(pulse)
    );
    assign sel_v[p] = hit && off[ADDR_W-1:2] == (ADDR_W-2)'(p);
    assign wr_sel   = bus.wr_en && sel_v[p];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q  <= '0;
        mask_q <= '0;
        edge_q <= '0;
      end else begin
        if (wr_sel && r == MMIO_OUT) out_q <= bus.wr_data[IO_W-1:0];
        if (wr_sel && r == MMIO_MASK) mask_q <= bus.wr_data[IO_W-1:0];
        edge_q <= (edge_q & ~((wr_sel && r == MMIO_EDGE) ? bus.wr_data[IO_W-1:0] : '0)) | pulse;
      end
    end
    assign fld_all[p*IO_W +: IO_W] = r == MMIO_OUT ? out_q : r == MMIO_IN ? in_q : r == MMIO_EDGE ? edge_q : mask_q;
    assign io_out[p*IO_W +: IO_W]  = out_q;
    assign pend_v[p]               = |(edge_q & mask_q);
  end
  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < N_PORTS; p++) if (sel_v[p]) rd_mux = DATA_W'(fld_all[p*IO_W +: IO_W]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq        <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_mux;
      irq <= |pend_v;
    end
  end
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_mmio_port_bank.sv
// tb_mmio_port_bank: directed scenarios plus randomized traffic checked against a register-level model of the bank
module tb_mmio_port_bank;
  localparam logic [9:0] BASE = 10'h3C0;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] io_in = 8'h00;
  logic [7:0] io_out;
  logic       irq;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] out_m [2];
  logic [3:0] mask_m[2];
  logic [3:0] edge_m[2];
  logic [7:0] pins;
  mmio_port_bank_if #(.ADDR_W(10), .DATA_W(8)) bus ();
  mmio_port_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .io_in (io_in),
    .io_out(io_out),
    .irq   (irq)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    bus.addr = a;
    bus.wr_data = d;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic rd(input logic [9:0] a, output logic [7:0] d, output logic v);
    bus.addr = a;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    d = bus.rd_data;
    v = bus.rd_valid;
  endtask
  function automatic logic [7:0] model_rd(input logic [9:0] a);
    int o = int'(a) - int'(BASE);
    int p = o / 4;
    if (o < 0 || o >= 8) return 8'h00;
    case (o % 4)
      0: return {4'h0, out_m[p]};
      1: return {4'h0, pins[p*4 +: 4]};
      2: return {4'h0, edge_m[p]};
      default: return {4'h0, mask_m[p]};
    endcase
  endfunction
  task automatic test_reset;
    logic [7:0] d;
    logic       v;
    rst_n = 1'b0;
    io_in = 8'hFF;
    bus.addr = BASE;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checks++;
    if (io_out !== 8'h00) begin errors++; $display("FAIL reset_io_out got %h exp 00", io_out); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    for (int p = 0; p < 2; p++) begin
      rd(BASE + 10'(4*p + 2), d, v);
      checks++;
      if (d !== 8'h00 || v !== 1'b1) begin errors++; $display("FAIL reset_edge%0d got %h/%b exp 00/1", p, d, v); end
      rd(BASE + 10'(4*p + 1), d, v);
      checks++;
      if (d !== 8'h0F) begin errors++; $display("FAIL reset_in%0d got %h exp 0f", p, d); end
    end
  endtask
  task automatic test_write_read;
    logic [7:0] d;
    logic       v;
    wr(BASE, 8'hA5);
    checks++;
    if (io_out[3:0] !== 4'h5) begin errors++; $display("FAIL wr_io_out got %h exp 5", io_out[3:0]); end
    rd(BASE, d, v);
    checks++;
    if (d !== 8'h05 || v !== 1'b1) begin errors++; $display("FAIL rd_out got %h/%b exp 05/1", d, v); end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got %b exp 0", bus.rd_valid); end
    checks++;
    if (bus.rd_data !== 8'h05) begin errors++; $display("FAIL rd_hold got %h exp 05", bus.rd_data); end
  endtask
  task automatic test_sync_latency;
    logic [7:0] d;
    logic       v;
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h00;
    exp_seq[1] = 8'h00;
    exp_seq[2] = 8'h02;
    io_in = 8'h00;
    repeat (5) tick();
    wr(BASE + 10'd2, 8'hFF);
    wr(BASE + 10'd6, 8'hFF);
    rd(BASE + 10'd6, d, v);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL w1c_all got %h exp 00", d); end
    io_in[5] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd(BASE + 10'd5, d, v);
      checks++;
      if (d !== exp_seq[i]) begin errors++; $display("FAIL sync_in_c%0d got %h exp %h", i + 1, d, exp_seq[i]); end
    end
    rd(BASE + 10'd6, d, v);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL sync_edge got %h exp 02", d); end
  endtask
  task automatic test_irq_w1c;
    logic [7:0] d;
    logic       v;
    wr(BASE + 10'd7, 8'h02);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag got %b exp 0", irq); end
    tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
    wr(BASE + 10'd6, 8'h02);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_clr_lag got %b exp 1", irq); end
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
    rd(BASE + 10'd6, d, v);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL w1c_edge got %h exp 00", d); end
    io_in[5] = 1'b0;
    tick();
    tick();
    wr(BASE + 10'd6, 8'h02);
    rd(BASE + 10'd6, d, v);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL set_wins got %h exp 02", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b exp 1", irq); end
  endtask
  task automatic test_miss_boundary;
    logic [7:0] d;
    logic       v;
    logic [9:0] addrs [4];
    logic       hits [4];
    addrs[0] = BASE - 10'd1; hits[0] = 1'b0;
    addrs[1] = BASE;         hits[1] = 1'b1;
    addrs[2] = BASE + 10'd7; hits[2] = 1'b1;
    addrs[3] = BASE + 10'd8; hits[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.addr = addrs[i];
      #1;
      checks++;
      if (bus.hit !== hits[i]) begin errors++; $display("FAIL hit_%h got %b exp %b", addrs[i], bus.hit, hits[i]); end
    end
    wr(BASE + 10'd8, 8'hFF);
    wr(BASE - 10'd1, 8'hFF);
    wr(BASE + 10'd1, 8'hFF);
    rd(BASE + 10'd8, d, v);
    checks++;
    if (d !== 8'h00 || v !== 1'b1) begin errors++; $display("FAIL miss_rd got %h/%b exp 00/1", d, v); end
    rd(BASE + 10'd4, d, v);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL miss_out1 got %h exp 00", d); end
    rd(BASE + 10'd3, d, v);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL miss_mask0 got %h exp 00", d); end
    rd(BASE + 10'd1, d, v);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL wr_in_ignored got %h exp 00", d); end
    checks++;
    if (io_out !== 8'h05) begin errors++; $display("FAIL miss_io_out got %h exp 05", io_out); end
    bus.addr = BASE;
    bus.wr_data = 8'h03;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_data !== 8'h05) begin errors++; $display("FAIL rdwr_old got %h exp 05", bus.rd_data); end
    checks++;
    if (io_out[3:0] !== 4'h3) begin errors++; $display("FAIL rdwr_new got %h exp 3", io_out[3:0]); end
  endtask
  task automatic test_random;
    logic [7:0] d;
    logic       v;
    logic [7:0] np;
    logic [9:0] a;
    for (int p = 0; p < 2; p++) begin
      wr(BASE + 10'(4*p), 8'h00);
      wr(BASE + 10'(4*p + 3), 8'h00);
      wr(BASE + 10'(4*p + 2), 8'hFF);
      out_m[p] = 4'h0;
      mask_m[p] = 4'h0;
      edge_m[p] = 4'h0;
    end
    pins = io_in;
    for (int it = 0; it < 120; it++) begin
      int op = int'($urandom_range(0, 3));
      if (op == 0) begin
        np = 8'($urandom);
        io_in = np;
        repeat (5) tick();
        for (int p = 0; p < 2; p++) edge_m[p] = edge_m[p] | (pins[p*4 +: 4] ^ np[p*4 +: 4]);
        pins = np;
      end else if (op == 1) begin
        a = BASE - 10'd2 + 10'($urandom_range(0, 11));
        d = 8'($urandom);
        wr(a, d);
        if (a >= BASE && a < BASE + 10'd8) begin
          int o = int'(a - BASE);
          if (o % 4 == 0) out_m[o/4] = d[3:0];
          if (o % 4 == 2) edge_m[o/4] = edge_m[o/4] & ~d[3:0];
          if (o % 4 == 3) mask_m[o/4] = d[3:0];
        end
      end else begin
        a = BASE - 10'd2 + 10'($urandom_range(0, 11));
        rd(a, d, v);
        checks++;
        if (d !== model_rd(a) || v !== 1'b1) begin errors++; $display("FAIL rand_rd_%h got %h/%b exp %h/1", a, d, v, model_rd(a)); end
      end
      tick();
      checks++;
      if (irq !== |((edge_m[0] & mask_m[0]) | (edge_m[1] & mask_m[1]))) begin
        errors++;
        $display("FAIL rand_irq it%0d got %b exp %b", it, irq, |((edge_m[0] & mask_m[0]) | (edge_m[1] & mask_m[1])));
      end
      checks++;
      if (io_out !== {out_m[1], out_m[0]}) begin errors++; $display("FAIL rand_io_out it%0d got %h exp %h", it, io_out, {out_m[1], out_m[0]}); end
    end
  endtask
  task automatic test_reset_mid;
    logic [7:0] d;
    logic       v;
    int         seen = 0;
    wr(BASE + 10'd3, 8'h0F);
    wr(BASE, 8'h0A);
    io_in = 8'h00;
    bus.addr = BASE;
    bus.rd_en = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    bus.rd_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) rst_n = 1'b1;
      tick();
      if (bus.rd_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_rd_valid got %0d pulses exp 0", seen); end
    checks++;
    if (io_out !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL mid_outs got %h/%b exp 00/0", io_out, irq); end
    repeat (5) tick();
    for (int r = 0; r < 8; r++) begin
      rd(BASE + 10'(r), d, v);
      checks++;
      if (d !== 8'h00 || v !== 1'b1) begin errors++; $display("FAIL mid_reg%0d got %h/%b exp 00/1", r, d, v); end
    end
  endtask
  initial begin
    bus.addr = '0;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.rd_en = 1'b0;
    test_reset();
    test_write_read();
    test_sync_latency();
    test_irq_w1c();
    test_miss_boundary();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
